// File: rtl/ov_sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master between two requesters.
// Writes to DELAY_SUBADDR become timed pauses instead of bus transfers,
// and a watchdog aborts any transfer that never signals end.
module ov_sccb_arbiter #(
   parameter logic [7:0]  DELAY_SUBADDR  = 8'hF0,
   parameter logic [23:0] DELAY_CYCLES   = 24'd1_000_000,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       rd0,
   input  logic [7:0] addr0,
   input  logic [7:0] subaddr0,
   input  logic [7:0] wdata0,
   input  logic       req1,
   input  logic       rd1,
   input  logic [7:0] addr1,
   input  logic [7:0] subaddr1,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       done0,
   output logic       err0,
   output logic [7:0] rdata0,
   output logic       ack1,
   output logic       done1,
   output logic       err1,
   output logic [7:0] rdata1,
   output logic       owner,
   output logic [7:0] m_addr,
   output logic [7:0] m_subaddr,
   output logic [7:0] m_wdata,
   output logic       m_start,
   input  logic       m_busy,
   input  logic       m_end,
   input  logic [7:0] m_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DELAY = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        owner_q;
   logic [23:0] cnt_q;
   logic        ack0_q, ack1_q;
   logic        err_q;
   logic        rd_q;
   logic [7:0]  rdata0_q, rdata1_q;
   logic [7:0]  addr_q, sub_q, wdata_q;

   logic        win0, win1;
   logic        sel_rd, sel_delay;
   logic [7:0]  sel_addr, sel_sub, sel_wdata;
   logic        timeout;
   logic        abort;

   // Arbitration and request field selection (only meaningful in S_IDLE).
   always_comb begin
      win0      = (state_q == S_IDLE) & req0 & (~req1 | owner_q);
      win1      = (state_q == S_IDLE) & req1 & (~req0 | ~owner_q);
      sel_rd    = win1 ? rd1      : rd0;
      sel_addr  = win1 ? addr1    : addr0;
      sel_sub   = win1 ? subaddr1 : subaddr0;
      sel_wdata = win1 ? wdata1   : wdata0;
      sel_delay = ~sel_rd & (sel_sub == DELAY_SUBADDR);
      timeout   = (cnt_q == TIMEOUT_CYCLES);
      // m_end wins over a watchdog expiry in the same cycle
      abort     = ((state_q == S_ISSUE) & timeout) |
                  ((state_q == S_WAIT) & ~m_end & timeout);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused encodings fall back to S_IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (win0 | win1) begin
               state_d = sel_delay ? S_DELAY : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (timeout) begin
               state_d = S_DONE;
            end else if (m_busy) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (m_end || timeout) begin
               state_d = S_DONE;
            end
         end
         S_DELAY: begin
            if (cnt_q == DELAY_CYCLES) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Grant bookkeeping, latched fields, watchdog/delay counter and read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q  <= 1'b1;
         cnt_q    <= 24'd0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         rdata0_q <= 8'h00;
         rdata1_q <= 8'h00;
         addr_q   <= 8'h00;
         sub_q    <= 8'h00;
         wdata_q  <= 8'h00;
      end else begin
         ack0_q <= win0;
         ack1_q <= win1;
         err_q  <= abort;
         // Counter is zero on entry to S_ISSUE/S_DELAY and stops being used
         // at its limit, so it never wraps within a transaction.
         if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            cnt_q <= 24'd0;
         end else begin
            cnt_q <= cnt_q + 24'd1;
         end
         if (win0 | win1) begin
            owner_q <= win1;
            rd_q    <= sel_rd;
            addr_q  <= sel_rd ? (sel_addr | 8'h01) : (sel_addr & 8'hFE);
            sub_q   <= sel_sub;
            wdata_q <= sel_wdata;
         end
         if ((state_q == S_WAIT) && m_end && rd_q) begin
            if (owner_q) begin
               rdata1_q <= m_rdata;
            end else begin
               rdata0_q <= m_rdata;
            end
         end
      end
   end

   // Outputs decoded from state and registers.
   always_comb begin
      m_start   = (state_q == S_ISSUE);
      done0     = (state_q == S_DONE) & ~owner_q;
      done1     = (state_q == S_DONE) & owner_q;
      err0      = done0 & err_q;
      err1      = done1 & err_q;
      ack0      = ack0_q;
      ack1      = ack1_q;
      rdata0    = rdata0_q;
      rdata1    = rdata1_q;
      owner     = owner_q;
      m_addr    = addr_q;
      m_subaddr = sub_q;
      m_wdata   = wdata_q;
   end

endmodule
